// File: rtl/clk_gate_pkg.sv
// Purpose : shared types and sizing helpers for the clock-gate enable controller.
// Contents: cg_state_e FSM encoding, cg_width() counter sizing, default wake-counter width.
// Ports   : none (package).
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } cg_state_e;

    // Bits needed to hold any value 0..max.
    function automatic int cg_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

    localparam int WAKE_CYCLES_DEF = 2;
    localparam int WAKE_CNT_W      = cg_width(WAKE_CYCLES_DEF);

endpackage

// File: rtl/cg_cnt.sv
// Purpose : small load/clear/increment/decrement counter with a terminal-count flag.
// Ports   : clk_i/rst_i (sync active-high), clr_i > ld_i > inc_i > dec_i priority,
//           ld_val_i load value, tc_o high while the count equals TC_VAL.
// Notes   : saturates at MAX_VAL on increment and at 0 on decrement.
module cg_cnt #(
    parameter int W       = 2,
    parameter int MAX_VAL = 3,
    parameter int TC_VAL  = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (inc_i && (cnt_q != W'(MAX_VAL))) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == W'(TC_VAL));

endmodule

// File: rtl/clk_gate_ctrl.sv
// Purpose : drives the enable of a latch+AND clock gate; wakes the downstream domain on
//           request, flags when its clock is usable, and gates it off after an idle period.
// Ports   : clk_i/rst_i ungated clock + sync active-high reset; req_i/busy_i/force_on_i
//           activity inputs; clk_en_o gate enable, ready_o domain usable, wake_cnt_o wake count.
// Notes   : every output is a flop, so no input reaches an output combinationally.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       busy_i,
    input  logic       force_on_i,
    output logic       clk_en_o,
    output logic       ready_o,
    output logic [7:0] wake_cnt_o
);

    localparam int WW = cg_width(WAKE_CYCLES);
    localparam int IW = cg_width(IDLE_CYCLES);

    cg_state_e state_q;
    cg_state_e state_d;
    logic      clk_en_q;
    logic      ready_q;
    logic [7:0] wake_cnt_q;

    logic act;
    logic wake;
    logic w_ld, w_dec, w_zero;
    logic i_clr, i_inc, i_tc;
    logic wc_inc;

    // busy_i keeps a running domain alive but cannot start a stopped one.
    assign act  = req_i | busy_i | force_on_i;
    assign wake = req_i | force_on_i;

    // Wake counter: loaded with WAKE_CYCLES-1 on wake, counts down to 0.
    cg_cnt #(
        .W       (WW),
        .MAX_VAL (WAKE_CYCLES - 1),
        .TC_VAL  (0)
    ) u_wake_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (1'b0),
        .ld_i     (w_ld),
        .ld_val_i (WW'(WAKE_CYCLES - 1)),
        .inc_i    (1'b0),
        .dec_i    (w_dec),
        .tc_o     (w_zero)
    );

    // Idle counter: counts consecutive inactive ON cycles up to IDLE_CYCLES-1.
    cg_cnt #(
        .W       (IW),
        .MAX_VAL (IDLE_CYCLES - 1),
        .TC_VAL  (IDLE_CYCLES - 1)
    ) u_idle_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (i_clr),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .inc_i    (i_inc),
        .dec_i    (1'b0),
        .tc_o     (i_tc)
    );

    always_comb begin
        state_d = state_q;
        w_ld    = 1'b0;
        w_dec   = 1'b0;
        i_clr   = 1'b0;
        i_inc   = 1'b0;
        wc_inc  = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (wake) begin
                    state_d = ST_WAKE;
                    w_ld    = 1'b1;
                    wc_inc  = 1'b1;
                end
            end
            ST_WAKE: begin
                // Inputs are ignored here: a started wake always completes.
                if (w_zero) begin
                    state_d = ST_ON;
                    i_clr   = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_ON: begin
                // Activity at terminal count wins over going to DRAIN.
                if (act) begin
                    i_clr = 1'b1;
                end else if (i_tc) begin
                    state_d = ST_DRAIN;
                end else begin
                    i_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Clock is still running, so a return to ON needs no wake delay.
                if (act) begin
                    state_d = ST_ON;
                    i_clr   = 1'b1;
                end else begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_OFF;
            clk_en_q   <= 1'b0;
            ready_q    <= 1'b0;
            wake_cnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            clk_en_q <= (state_d != ST_OFF);
            ready_q  <= (state_d == ST_ON);
            if (wc_inc) begin
                wake_cnt_q <= wake_cnt_q + 8'd1;
            end
        end
    end

    assign clk_en_o   = clk_en_q;
    assign ready_o    = ready_q;
    assign wake_cnt_o = wake_cnt_q;

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Enable controller for the latch-plus-AND clock gate built from 74LVC cells: it decides when a downstream clock domain runs and drives the gate's enable input. It runs on the ungated clock, wakes the domain on request, signals when the gated clock is usable, and gates the domain off after a programmable idle period. It is the producer end of the gate-enable interface; the gate cell samples `clk_en_o` through its transparent-low latch.

## Interface
- `IDLE_CYCLES`, default 8: consecutive idle cycles in ON before gating off; must be ≥1.
- `WAKE_CYCLES`, default 2: cycles of running clock before `ready_o` asserts; must be ≥1.
- `clk_i`  in  1  ungated clock. One clock; reset is synchronous and active-high.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  1  activity request from upstream; level-sensitive.
- `busy_i`  in  1  downstream domain is busy; holds the clock on, but does not wake it.
- `force_on_i`  in  1  override; forces the clock on and blocks idle gating.
- `clk_en_o`  out  1  enable to the clock gate; 1 = clock runs.
- `ready_o`  out  1  gated clock is stable and the domain may be used.
- `wake_cnt_o`  out  8  number of OFF→WAKE transitions; wraps 255→0.

## Operation
- State machine states: OFF, WAKE, ON, DRAIN. All outputs are decoded from registered state, so there are no combinational input-to-output paths.
- `clk_en_o` = (state ≠ OFF). `ready_o` = (state == ON).
- The activity term is `act = req_i | busy_i | force_on_i`. The wake term is `wake = req_i | force_on_i`.
- **OFF**
  - If `wake`: go to WAKE, load the wake counter with WAKE_CYCLES−1, and increment `wake_cnt_o`.
  - `busy_i` alone has no effect.
- **WAKE**
  - If the wake counter is 0: go to ON and clear the idle counter.
  - Otherwise: decrement the wake counter.
  - Inputs are ignored while in WAKE; WAKE cannot abort back to OFF.
- **ON**
  - If `act`: clear the idle counter.
  - Otherwise, if the idle counter == IDLE_CYCLES−1: go to DRAIN.
  - Otherwise: increment the idle counter.
- **DRAIN** (lasts exactly 1 cycle; the clock is still enabled for the final edge)
  - If `act`: return to ON and clear the idle counter. No wake delay applies because the clock never stopped.
  - Otherwise: go to OFF.
- Counter widths are $clog2(max+1) of the respective parameter. Counters must never underflow or overflow.
- `wake_cnt_o` is an 8-bit unsigned count with modulo-256 wrap.

## Timing
- Reset: state = OFF, `clk_en_o` = 0, `ready_o` = 0, `wake_cnt_o` = 0, both counters = 0. Reset overrides all inputs.
- Reset asserted mid-WAKE, mid-ON or mid-DRAIN forces OFF on the next edge. The gate therefore closes one cycle after `rst_i` is sampled high.
- Wake latency: `req_i` sampled high at edge n in OFF gives:
  - `clk_en_o` = 1 after edge n.
  - `ready_o` = 1 after edge n+WAKE_CYCLES.
- Gate-off latency: the last active cycle is sampled at edge m in ON. Then:
  - `ready_o` = 0 after edge m+IDLE_CYCLES (state DRAIN).
  - `clk_en_o` = 0 after edge m+IDLE_CYCLES+1.
- Activity in the same cycle the idle counter reaches terminal count wins: the state stays ON and the counter clears.
- `force_on_i` held high keeps the state in ON indefinitely. Once released, normal idle counting applies.

## Structure
- Package `clk_gate_pkg` holds:
  - the state enum `cg_state_e` {OFF, WAKE, ON, DRAIN};
  - the wake-counter width constant.
- Sub-module `cg_cnt`: a parameterised load/clear/increment/decrement counter with terminal-count flag. It is instantiated twice, once for the wake counter and once for the idle counter.
- The top level contains the FSM, output decode and `wake_cnt_o` register. Target size is about 150–250 lines in total.

## Test plan
- Reset then `req_i` pulse for 1 cycle (defaults) → `clk_en_o` rises 1 cycle later; `ready_o` rises 2 cycles after that; `wake_cnt_o` = 1; `ready_o` falls 8 cycles after `req_i` drops; `clk_en_o` falls 1 cycle later.
- `busy_i` = 1 while in OFF → state stays OFF and `clk_en_o` stays 0. Then `req_i` pulse followed by `busy_i` held for 20 cycles → `ready_o` stays 1 throughout and gates off 8 cycles after `busy_i` falls.
- `req_i` pulse exactly in the DRAIN cycle → `ready_o` returns to 1 on the next cycle, `clk_en_o` never drops, and `wake_cnt_o` is unchanged.
- `req_i` reasserted on the 8th idle cycle, at terminal count → no DRAIN, `ready_o` stays 1.
- `rst_i` asserted during WAKE and during ON → all outputs are 0 and state is OFF after 1 edge; a subsequent `req_i` wakes normally.
- 256 wake cycles with `IDLE_CYCLES`=1 and `WAKE_CYCLES`=1 → `wake_cnt_o` wraps to 0; per-wake latency is `clk_en_o` +1 and `ready_o` +2.
